// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU commands in a 2-entry FIFO, issues them one at a time and returns registered results
module alu_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       io_cmd_valid,
   output logic       io_cmd_ready,
   input  logic [1:0] io_cmd_bits_fn,
   input  logic [3:0] io_cmd_bits_a,
   input  logic [3:0] io_cmd_bits_b,
   input  logic       io_cmd_bits_useAcc,
   output logic       io_alu_start,
   output logic [1:0] io_alu_fn,
   output logic [3:0] io_alu_a,
   output logic [3:0] io_alu_b,
   input  logic [3:0] io_alu_result,
   output logic       io_resp_valid,
   input  logic       io_resp_ready,
   output logic [3:0] io_resp_bits_result,
   output logic [1:0] io_resp_bits_fn,
   output logic [7:0] io_count
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   typedef struct packed {
      logic [1:0] fn;
      logic [3:0] a;
      logic [3:0] b;
      logic       use_acc;
   } cmd_t;
   cmd_t       fifo_q [2];
   cmd_t       head;
   logic       wr_ptr_q, rd_ptr_q;
   logic [1:0] cnt_q, cnt_d;
   logic       push, pop;
   state_t     state_q;
   logic [3:0] acc_q;
   logic       start_q;
   logic [1:0] alu_fn_q;
   logic [3:0] alu_a_q, alu_b_q;
   logic       resp_valid_q;
   logic [3:0] resp_result_q;
   logic [1:0] resp_fn_q;
   logic [7:0] count_q;
   // FIFO handshake: accept while not full, pop only when the FSM is idle
   always_comb begin
      io_cmd_ready = cnt_q != 2'd2;
      push = io_cmd_valid & io_cmd_ready;
      pop = (state_q == IDLE) & (cnt_q != 2'd0);
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      head = fifo_q[rd_ptr_q];
   end
   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push) fifo_q[wr_ptr_q] <= '{io_cmd_bits_fn, io_cmd_bits_a, io_cmd_bits_b, io_cmd_bits_useAcc};
         wr_ptr_q <= wr_ptr_q ^ push;
         rd_ptr_q <= rd_ptr_q ^ pop;
         cnt_q <= cnt_d;
      end
   end
   // Issue/response sequencing; ALU drive and response are registered so ISSUE sees stable operands
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q <= 4'd0;
         start_q <= 1'b0;
         alu_fn_q <= 2'd0;
         alu_a_q <= 4'd0;
         alu_b_q <= 4'd0;
         resp_valid_q <= 1'b0;
         resp_result_q <= 4'd0;
         resp_fn_q <= 2'd0;
         count_q <= 8'd0;
      end else begin
         case (state_q)
            IDLE: if (pop) begin
               state_q <= ISSUE;
               start_q <= 1'b1;
               alu_fn_q <= head.fn;
               alu_a_q <= head.use_acc ? acc_q : head.a;
               alu_b_q <= head.b;
            end
            ISSUE: begin
               state_q <= RESP;
               start_q <= 1'b0;
               alu_fn_q <= 2'd0;
               alu_a_q <= 4'd0;
               alu_b_q <= 4'd0;
               resp_result_q <= io_alu_result;
               acc_q <= io_alu_result;
               resp_fn_q <= alu_fn_q;
               resp_valid_q <= 1'b1;
            end
            RESP: if (io_resp_ready) begin
               state_q <= IDLE;
               resp_valid_q <= 1'b0;
               count_q <= count_q + 8'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign io_alu_start = start_q;
   assign io_alu_fn = alu_fn_q;
   assign io_alu_a = alu_a_q;
   assign io_alu_b = alu_b_q;
   assign io_resp_valid = resp_valid_q;
   assign io_resp_bits_result = resp_result_q;
   assign io_resp_bits_fn = resp_fn_q;
   assign io_count = count_q;
endmodule
